// File: rtl/lcd_init_writer.sv
// Walks the init/fill ROM one word per pass and replays it on an 8080-style LCD write bus.
// Eight clocks per bus write at default timing; adv_o pulses once per consumed word, and done_o latches at the end marker.
module lcd_init_writer #(
  parameter int ROM_W      = 18,
  parameter int ROM_LAT    = 1,
  parameter int T_SU       = 1,
  parameter int T_WRL      = 2,
  parameter int T_WRH      = 2,
  parameter int DELAY_UNIT = 50
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [ROM_W-1:0] rom_data_i,
  input  logic             init_fin_i,
  output logic             adv_o,
  output logic             lcd_cs_n,
  output logic             lcd_rs,
  output logic             lcd_wr_n,
  output logic             lcd_rd_n,
  output logic [15:0]      lcd_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PH_MAX_A = (ROM_LAT > T_SU) ? ROM_LAT : T_SU;
  localparam int PH_MAX_B = (T_WRL > T_WRH) ? T_WRL : T_WRH;
  localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int PS_W     = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

  localparam logic [PH_W-1:0] FETCH_LAST = PH_W'(ROM_LAT);
  localparam logic [PH_W-1:0] SU_LAST    = PH_W'(T_SU - 1);
  localparam logic [PH_W-1:0] WRL_LAST   = PH_W'(T_WRL - 1);
  localparam logic [PH_W-1:0] WRH_LAST   = PH_W'(T_WRH - 1);
  localparam logic [PS_W-1:0] PRE_LAST   = PS_W'(DELAY_UNIT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SETUP, WRL, WRH, DELAY, ADV, DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph_cnt;
  logic [PS_W-1:0]   pre_cnt;
  logic [15:0]       dly_cnt;
  logic [1:0]        rom_type;
  logic [15:0]       payload;

  assign rom_type = rom_data_i[ROM_W-1 -: 2];
  assign payload  = rom_data_i[15:0];
  assign lcd_rd_n = 1'b1;

  // Outputs are registered alongside the state, so they always reflect the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      pre_cnt    <= '0;
      dly_cnt    <= '0;
      adv_o      <= 1'b0;
      lcd_cs_n   <= 1'b1;
      lcd_rs     <= 1'b1;
      lcd_wr_n   <= 1'b1;
      lcd_data_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      adv_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= FETCH;
            ph_cnt <= '0;
            busy_o <= 1'b1;
          end
        end

        // The first ROM_LAT cycles let the registered ROM catch up with the current address.
        FETCH: begin
          if (ph_cnt != FETCH_LAST) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end else begin
            ph_cnt <= '0;
            if (init_fin_i) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              case (rom_type)
                2'b00, 2'b01: begin
                  lcd_rs     <= rom_type[0];
                  lcd_data_o <= payload;
                  lcd_cs_n   <= 1'b0;
                  state      <= SETUP;
                end
                2'b10: begin
                  if (payload == 16'd0) begin
                    state <= ADV;
                    adv_o <= 1'b1;
                  end else begin
                    dly_cnt <= payload;
                    pre_cnt <= '0;
                    state   <= DELAY;
                  end
                end
                default: begin
                  state <= ADV;
                  adv_o <= 1'b1;
                end
              endcase
            end
          end
        end

        SETUP: begin
          if (ph_cnt != SU_LAST) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end else begin
            ph_cnt   <= '0;
            lcd_wr_n <= 1'b0;
            state    <= WRL;
          end
        end

        WRL: begin
          if (ph_cnt != WRL_LAST) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end else begin
            ph_cnt   <= '0;
            lcd_wr_n <= 1'b1;
            state    <= WRH;
          end
        end

        WRH: begin
          if (ph_cnt != WRH_LAST) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end else begin
            ph_cnt   <= '0;
            lcd_cs_n <= 1'b1;
            adv_o    <= 1'b1;
            state    <= ADV;
          end
        end

        // Prescaler ticks once per DELAY_UNIT clocks; dly_cnt counts remaining payload units.
        DELAY: begin
          if (pre_cnt != PRE_LAST) begin
            pre_cnt <= pre_cnt + PS_W'(1);
          end else begin
            pre_cnt <= '0;
            dly_cnt <= dly_cnt - 16'd1;
            if (dly_cnt == 16'd1) begin
              adv_o <= 1'b1;
              state <= ADV;
            end
          end
        end

        ADV: begin
          ph_cnt <= '0;
          state  <= FETCH;
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_init_writer.sv
// Directed bench for lcd_init_writer with a registered ROM and an address-generator model (fill hold).
module tb_lcd_init_writer;

  localparam int NS = 220;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [17:0] rom_q;
  logic        init_fin;
  logic        adv_o, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, busy_o, done_o;
  logic [15:0] lcd_data_o;

  logic [17:0] rom [0:15];
  int end_addr = 1, fill_addr = 99, fill_reps = 1;
  int gaddr, grep;
  int n_cmp = 0, n_err = 0;

  logic        wr_h [NS];
  logic        cs_h [NS];
  logic        adv_h [NS];
  logic        rs_h [NS];
  logic        busy_h [NS];
  logic        done_h [NS];
  logic [15:0] dat_h [NS];

  lcd_init_writer #(.DELAY_UNIT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .rom_data_i (rom_q),
    .init_fin_i (init_fin),
    .adv_o      (adv_o),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_rs     (lcd_rs),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
    .lcd_data_o (lcd_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Generator model: address advances on adv_o, except the fill address is held fill_reps times.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gaddr <= 0;
      grep  <= 0;
    end else if (adv_o) begin
      if (gaddr == fill_addr && grep < fill_reps - 1) begin
        grep <= grep + 1;
      end else begin
        gaddr <= gaddr + 1;
        grep  <= 0;
      end
    end
  end

  always @(posedge clk) rom_q <= rom[gaddr[3:0]];
  assign init_fin = (gaddr == end_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setup(input int e_a, input int f_a, input int reps);
    rstn    = 1'b0;
    start_i = 1'b0;
    end_addr  = e_a;
    fill_addr = f_a;
    fill_reps = reps;
    for (int i = 0; i < 16; i++) rom[i] = 18'h3FFFF;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start, then record n negedge samples; sample 0 is the first FETCH cycle.
  task automatic run_start(input int n, input int s0, input int s1);
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_h[k]   = lcd_wr_n;
      cs_h[k]   = lcd_cs_n;
      adv_h[k]  = adv_o;
      rs_h[k]   = lcd_rs;
      busy_h[k] = busy_o;
      done_h[k] = done_o;
      dat_h[k]  = lcd_data_o;
      start_i   = (k == s0 || k == s0 + 1 || k == s1);
    end
    start_i = 1'b0;
  endtask

  function automatic logic get_sig(input int sel, input int k);
    case (sel)
      0:       return wr_h[k];
      1:       return cs_h[k];
      2:       return adv_h[k];
      default: return done_h[k];
    endcase
  endfunction

  function automatic int count_sig(input int sel, input int lo, input int hi, input logic val);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (get_sig(sel, k) == val) c++;
    return c;
  endfunction

  function automatic int first_sig(input int sel, input int lo, input int hi, input logic val);
    for (int k = lo; k <= hi; k++) if (get_sig(sel, k) == val) return k;
    return -1;
  endfunction

  initial begin
    logic [16:0] strobes [$];
    logic [17:0] w;
    int          a;

    // Reset values
    setup(1, 99, 1);
    check("rst_ctl", {lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n}, 4'hF);
    check("rst_data", lcd_data_o, 16'h0000);
    check("rst_flags", {adv_o, busy_o, done_o}, 3'b000);

    // 1: single command word, then end marker
    rom[0] = 18'h00028;
    run_start(16, -10, -10);
    check("t1_busy0", busy_h[0], 1);
    check("t1_cs_setup", cs_h[2], 0);
    check("t1_wr_seq", {wr_h[2], wr_h[3], wr_h[4], wr_h[5]}, 4'b1001);
    check("t1_wr_low_cnt", count_sig(0, 0, 15, 1'b0), 2);
    check("t1_rs", rs_h[3], 0);
    check("t1_data", dat_h[3], 16'h0028);
    check("t1_adv_cnt", count_sig(2, 0, 15, 1'b1), 1);
    check("t1_adv_at", first_sig(2, 0, 15, 1'b1), 7);
    check("t1_done_at", first_sig(3, 0, 15, 1'b1), 10);
    check("t1_busy_end", busy_h[15], 0);

    // 2: data word, data held while wr_n rises
    setup(1, 99, 1);
    rom[0] = 18'h1ABCD;
    run_start(12, -10, -10);
    check("t2_rs", rs_h[3], 1);
    check("t2_data_low", dat_h[4], 16'hABCD);
    check("t2_wr_rise", {wr_h[4], wr_h[5]}, 2'b01);
    check("t2_data_rise", dat_h[5], 16'hABCD);

    // 3: delay 3 units of 4 clocks
    setup(1, 99, 1);
    rom[0] = 18'h20003;
    run_start(21, -10, -10);
    check("t3_cs_low_cnt", count_sig(1, 0, 20, 1'b0), 0);
    check("t3_wr_low_cnt", count_sig(0, 0, 20, 1'b0), 0);
    check("t3_adv_at", first_sig(2, 0, 20, 1'b1), 14);
    check("t3_adv_cnt", count_sig(2, 0, 20, 1'b1), 1);
    check("t3_done_at", first_sig(3, 0, 20, 1'b1), 17);

    // 3b: zero delay
    setup(1, 99, 1);
    rom[0] = 18'h20000;
    run_start(8, -10, -10);
    check("t3b_adv_at", first_sig(2, 0, 7, 1'b1), 2);
    check("t3b_done_at", first_sig(3, 0, 7, 1'b1), 5);

    // 4: reserved word is a NOP
    setup(1, 99, 1);
    rom[0] = 18'h31234;
    run_start(8, -10, -10);
    check("t4_adv_at", first_sig(2, 0, 7, 1'b1), 2);
    check("t4_wr_low_cnt", count_sig(0, 0, 7, 1'b0), 0);
    check("t4_cs_low_cnt", count_sig(1, 0, 7, 1'b0), 0);
    check("t4_data", dat_h[3], 16'h0000);
    check("t4_done_at", first_sig(3, 0, 7, 1'b1), 5);

    // 5: reset during WRL, then restart
    setup(1, 99, 1);
    rom[0] = 18'h05A5A;
    run_start(4, -10, -10);
    check("t5_in_wrl", {wr_h[3], cs_h[3]}, 2'b00);
    rstn = 1'b0;
    #1;
    check("t5_rst_bus", {lcd_wr_n, lcd_cs_n, lcd_rs}, 3'b111);
    check("t5_rst_data", lcd_data_o, 16'h0000);
    check("t5_rst_busy", busy_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle", {lcd_wr_n, lcd_cs_n, adv_o, busy_o, done_o}, 5'b11000);
    run_start(12, -10, -10);
    check("t5_data", dat_h[3], 16'h5A5A);
    check("t5_adv_at", first_sig(2, 0, 11, 1'b1), 7);
    check("t5_done_at", first_sig(3, 0, 11, 1'b1), 10);

    // 6: 10 init words, fill word held for 5 writes, end marker; spurious starts while busy and done
    setup(11, 10, 5);
    rom[0] = 18'h00011; rom[1] = 18'h00036; rom[2] = 18'h10048; rom[3] = 18'h0003A;
    rom[4] = 18'h10055; rom[5] = 18'h0002A; rom[6] = 18'h10000; rom[7] = 18'h100EF;
    rom[8] = 18'h0002B; rom[9] = 18'h0002C; rom[10] = 18'h1F800;
    run_start(200, 40, 190);
    for (int k = 1; k < 200; k++)
      if (wr_h[k] == 1'b0 && wr_h[k-1] == 1'b1) strobes.push_back({rs_h[k], dat_h[k]});
    check("t6_strobes", strobes.size(), 15);
    check("t6_adv_cnt", count_sig(2, 0, 199, 1'b1), 15);
    for (int i = 0; i < 15 && i < strobes.size(); i++) begin
      a = (i < 10) ? i : 10;
      w = rom[a];
      check($sformatf("t6_word%0d", i), strobes[i], w[16:0]);
    end
    check("t6_done_at", first_sig(3, 0, 199, 1'b1), 122);
    check("t6_done_held", count_sig(3, 0, 199, 1'b1), 78);
    check("t6_end_flags", {busy_h[199], done_h[199]}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
